pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//   Owns the program counter and sequences instruction fetch over a req/ack instruction-memory port.
//   Applies branch/jump redirects and computes the branch target as pc+4+(offset<<2).
//   Delivers one fetched instruction at a time to the decode stage through a valid/ready handshake.
//   Sits between instruction memory and the IF/ID boundary, replacing the free-running PC register.
// PARAMETERS
//   RESET_PC  32'h0000_0000  fetch address after reset (word aligned)
// PORTS
//   clk         in   1   clock, all state updates on rising edge
//   rst_n       in   1   asynchronous active-low reset
//   imem_req    out  1   fetch request, held until imem_ack
//   imem_addr   out  32  fetch address, stable while imem_req=1
//   imem_ack    in   1   transfer complete this cycle, imem_rdata valid
//   imem_rdata  in   32  instruction word
//   if_valid    out  1   if_instr/if_pc hold a fetched instruction
//   if_instr    out  32  fetched instruction
//   if_pc       out  32  address of if_instr
//   id_ready    in   1   decode accepts if_instr this cycle
//   br_taken    in   1   taken-branch redirect (1-cycle pulse)
//   jmp         in   1   jump redirect (1-cycle pulse)
//   br_pc       in   32  PC of the redirecting branch/jump
//   br_imm      in   32  sign-extended word offset of the branch
//   jmp_idx     in   26  jump target index
//   halt        in   1   level; stop issuing new fetches
// BEHAVIOUR
//   Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, kill=0; imem_req=0, imem_addr=RESET_PC,
//     if_valid=0, if_instr=0, if_pc=0. First request issued in first cycle after rst_n rises.
//   Targets (mod 2^32, no overflow flag): link=br_pc+4; branch=link+(br_imm<<2);
//     jump={link[31:28],jmp_idx,2'b00}. jmp has priority over br_taken if both high.
//   Sequential pc increment: pc+4, wraps 32'hFFFF_FFFC -> 32'h0000_0000.
//   States:
//     FETCH : imem_req=1, imem_addr=pc (unless halt and no request outstanding -> HALTED).
//             ack & !kill & no redirect: if_instr<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 -> VALID.
//             ack & (kill | redirect): data dropped, kill<=0, pc<=target if redirect -> FETCH.
//             no ack & redirect: pc<=target, kill<=1 (address held until ack; stale data dropped).
//     VALID : imem_req=0. id_ready & !redirect: if_valid<=0 -> FETCH (or HALTED if halt).
//             redirect (any id_ready): if_valid<=0, pc<=target -> FETCH (held instr discarded).
//     HALTED: imem_req=0, if_valid=0. redirect updates pc. halt=0 -> FETCH next cycle.
//   Handshake rules: imem_addr never changes while imem_req=1 and no ack; imem_req drops
//     for at least one cycle after each ack except for kill refetch (re-request allowed next cycle).
//   Throughput: zero-wait memory + id_ready=1 gives one instruction per 2 cycles; latency
//     req->if_valid = 1 cycle after ack.
//   if_instr/if_pc stable while if_valid=1 and id_ready=0.
//   halt asserted during outstanding fetch: fetch completes and is delivered; no new request.
//   Reset mid-transfer: everything returns to reset values immediately; pending ack ignored.
// TESTING
//   1. Reset, RESET_PC=0x100, zero-wait ack, id_ready=1 -> imem_addr 0x100,0x104,0x108; if_pc matches.
//   2. br_pc=0x200, br_imm=-2, br_taken in VALID -> if_valid drops, next imem_addr=0x1FC.
//   3. Redirect while imem_req=1, ack delayed 3 cycles -> addr held, data dropped, then fetch target.
//   4. jmp+br_taken same cycle, br_pc=0x1000_0000, jmp_idx=0x40 -> next imem_addr=0x1000_0100.
//   5. id_ready=0 for 4 cycles -> if_valid/if_instr/if_pc stable, imem_req=0; halt mid-fetch -> HALTED.
//   6. pc=0xFFFF_FFFC fetch -> next imem_addr=0x0; rst_n low mid-transfer -> outputs reset at once.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer: req/ack fetch from imem,
// branch/jump redirect handling and a single-entry valid/ready slot toward decode.
`timescale 1ns/1ps

module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic        jmp,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm,
  input  logic [25:0] jmp_idx,
  input  logic        halt
);

  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_VALID  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic        r_req;
  logic [31:0] r_addr;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_kill_nxt;
  logic        w_req_nxt;
  logic [31:0] w_addr_nxt;
  logic        w_valid_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_ifpc_nxt;
  logic        w_start;

  logic        w_redir;
  logic [31:0] w_link;
  logic [31:0] w_br_tgt;
  logic [31:0] w_jmp_tgt;
  logic [31:0] w_target;

  // Redirect targets; jump wins when both redirects fire together
  assign w_redir   = jmp | br_taken;
  assign w_link    = br_pc + WORD_BYTES;
  assign w_br_tgt  = w_link + (br_imm << 2);
  assign w_jmp_tgt = {w_link[31:28], jmp_idx, 2'b00};
  assign w_target  = jmp ? w_jmp_tgt : w_br_tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= 32'h0;
      r_if_pc    <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_if_valid <= w_valid_nxt;
      r_if_instr <= w_instr_nxt;
      r_if_pc    <= w_ifpc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_valid_nxt = r_if_valid;
    w_instr_nxt = r_if_instr;
    w_ifpc_nxt  = r_if_pc;
    w_start     = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (r_req) begin
          if (imem_ack) begin
            if (r_kill || w_redir) begin
              // Stale or redirected data is dropped and the new pc re-requested at once
              w_kill_nxt = 1'b0;
              if (w_redir) w_pc_nxt = w_target;
              w_start = 1'b1;
            end else begin
              w_instr_nxt = imem_rdata;
              w_ifpc_nxt  = r_addr;
              w_valid_nxt = 1'b1;
              w_pc_nxt    = r_pc + WORD_BYTES;
              w_req_nxt   = 1'b0;
              w_state_nxt = S_VALID;
            end
          end else if (w_redir) begin
            // Address must stay put until ack; remember to discard that response
            w_pc_nxt   = w_target;
            w_kill_nxt = 1'b1;
          end
        end else begin
          if (w_redir) w_pc_nxt = w_target;
          if (halt) w_state_nxt = S_HALTED;
          else      w_start     = 1'b1;
        end
      end
      S_VALID: begin
        if (w_redir) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = w_target;
          w_start     = 1'b1;
        end else if (id_ready) begin
          w_valid_nxt = 1'b0;
          if (halt) w_state_nxt = S_HALTED;
          else      w_start     = 1'b1;
        end
      end
      S_HALTED: begin
        if (w_redir) w_pc_nxt = w_target;
        if (!halt)   w_start  = 1'b1;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    // Entering FETCH with no transfer in flight: launch a request from the new pc
    if (w_start) begin
      w_state_nxt = S_FETCH;
      w_req_nxt   = !halt;
      w_addr_nxt  = w_pc_nxt;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: wait-state imem model, delivery scoreboard,
// a redirect vector table and hand sequences for the multi-cycle corners.
`timescale 1ns/1ps

module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        br_taken;
  logic        jmp;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic [25:0] jmp_idx;
  logic        halt;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int mem_delay = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        use_jmp;
    logic        use_br;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [25:0] idx;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t vecs[5];

  pc_fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .br_taken(br_taken), .jmp(jmp),
    .br_pc(br_pc), .br_imm(br_imm), .jmp_idx(jmp_idx), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Instruction memory: acks after mem_delay wait cycles, checks address hold
  initial begin : imem_model
    bit          pend;
    logic [31:0] paddr;
    int          wcnt;
    pend = 1'b0; paddr = 32'h0; wcnt = 0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (!pend) begin
          pend  = 1'b1;
          paddr = imem_addr;
        end else begin
          chk("addr_hold", imem_addr, paddr);
        end
        if (wcnt >= mem_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wcnt       = 0;
          pend       = 1'b0;
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
        pend     = 1'b0;
      end
    end
  end

  // Delivery monitor: each accepted instruction must match the scoreboard head
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && id_ready && !br_taken && !jmp) begin
        if (sb.size() == 0) begin
          chk("unexpected_delivery", if_pc, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("deliver_pc", if_pc, e);
          chk("deliver_instr", if_instr, mem_word(e));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    for (int i = 0; i < 50 && !imem_req; i++) tick();
    chk(nm, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 50 && !if_valid; i++) tick();
    chk(nm, 32'(if_valid), 32'd1);
  endtask

  task automatic run_redirect(input int k);
    id_ready = 1'b0;
    halt     = 1'b0;
    wait_valid($sformatf("rd%0d_valid", k));
    br_pc    = vecs[k].pc;
    br_imm   = vecs[k].imm;
    jmp_idx  = vecs[k].idx;
    br_taken = vecs[k].use_br;
    jmp      = vecs[k].use_jmp;
    tick();
    br_taken = 1'b0;
    jmp      = 1'b0;
    chk($sformatf("rd%0d_drop", k), 32'(if_valid), 32'd0);
    chk($sformatf("rd%0d_req", k), 32'(imem_req), 32'd1);
    chk($sformatf("rd%0d_addr", k), imem_addr, vecs[k].exp_addr);
    sb.push_back(vecs[k].exp_addr);
    id_ready = 1'b1;
    halt     = 1'b1;
    repeat (6) tick();
    chk($sformatf("rd%0d_drain", k), 32'(sb.size()), 32'd0);
    chk($sformatf("rd%0d_idle", k), 32'(imem_req), 32'd0);
  endtask

  initial begin : main
    int t_rise[3];
    bit found;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0200, 32'hFFFF_FFFE, 26'h0,         32'h0000_01FC};
    vecs[1] = '{1'b1, 1'b1, 32'h1000_0000, 32'h0000_0005, 26'h40,        32'h1000_0100};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0300, 32'h0000_0003, 26'h0,         32'h0000_0310};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0000_0001, 26'h0,         32'h0000_0000};
    vecs[4] = '{1'b1, 1'b0, 32'hF000_0010, 32'h0000_0000, 26'h3FF_FFFF,  32'hFFFF_FFFC};

    rst_n = 1'b0; id_ready = 1'b1; halt = 1'b0; br_taken = 1'b0; jmp = 1'b0;
    br_pc = 32'h0; br_imm = 32'h0; jmp_idx = 26'h0;

    // Reset values
    repeat (3) tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0100);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);

    // Sequential fetch, zero-wait memory
    sb.push_back(32'h100); sb.push_back(32'h104); sb.push_back(32'h108);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req($sformatf("seq%0d_req", k));
      t_rise[k] = cyc;
      chk($sformatf("seq%0d_addr", k), imem_addr, 32'h100 + 32'(4 * k));
      if (k == 2) halt = 1'b1;
      tick();
      chk($sformatf("seq%0d_lat_valid", k), 32'(if_valid), 32'd1);
      chk($sformatf("seq%0d_if_pc", k), if_pc, 32'h100 + 32'(4 * k));
    end
    chk("seq_rate", 32'(t_rise[1] - t_rise[0]), 32'd2);
    chk("seq_rate2", 32'(t_rise[2] - t_rise[1]), 32'd2);
    repeat (4) tick();
    chk("seq_drain", 32'(sb.size()), 32'd0);
    chk("seq_halted", 32'(imem_req), 32'd0);

    // Redirect table
    for (int k = 0; k < 5; k++) run_redirect(k);

    // PC wraps past 0xFFFF_FFFC
    halt = 1'b0; id_ready = 1'b1;
    wait_req("wrap_req");
    chk("wrap_addr", imem_addr, 32'h0);
    sb.push_back(32'h0);
    halt = 1'b1;
    repeat (6) tick();
    chk("wrap_drain", 32'(sb.size()), 32'd0);

    // Redirect while a slow fetch is outstanding: address held, stale word dropped
    mem_delay = 3; halt = 1'b0;
    wait_req("kill_req");
    chk("kill_addr0", imem_addr, 32'h4);
    br_pc = 32'h400; br_imm = 32'h0; br_taken = 1'b1;
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("kill_hold_req%0d", i), 32'(imem_req), 32'd1);
      chk($sformatf("kill_hold_addr%0d", i), imem_addr, 32'h4);
      tick();
    end
    sb.push_back(32'h404);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && imem_addr == 32'h404) found = 1'b1;
      else tick();
    end
    chk("kill_refetch", 32'(found), 32'd1);
    halt = 1'b1;
    repeat (12) tick();
    chk("kill_drain", 32'(sb.size()), 32'd0);
    chk("kill_idle", 32'(imem_req), 32'd0);

    // Decode back-pressure holds the slot; then halt during an outstanding fetch
    mem_delay = 0; id_ready = 1'b0; halt = 1'b0;
    wait_valid("bp_valid");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("bp%0d_valid", i), 32'(if_valid), 32'd1);
      chk($sformatf("bp%0d_pc", i), if_pc, 32'h408);
      chk($sformatf("bp%0d_instr", i), if_instr, mem_word(32'h408));
      chk($sformatf("bp%0d_req", i), 32'(imem_req), 32'd0);
    end
    sb.push_back(32'h408); sb.push_back(32'h40C);
    mem_delay = 2;
    id_ready = 1'b1;
    wait_req("hm_req");
    chk("hm_addr", imem_addr, 32'h40C);
    halt = 1'b1;
    repeat (10) tick();
    chk("hm_drain", 32'(sb.size()), 32'd0);
    chk("hm_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hm_noreq%0d", i), 32'(imem_req), 32'd0);
      tick();
    end

    // Reset in the middle of a transfer
    mem_delay = 3; halt = 1'b0;
    wait_req("rmt_req");
    chk("rmt_addr", imem_addr, 32'h410);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rmt_req0", 32'(imem_req), 32'd0);
    chk("rmt_addr0", imem_addr, 32'h100);
    chk("rmt_valid0", 32'(if_valid), 32'd0);
    chk("rmt_pc0", if_pc, 32'h0);
    chk("rmt_instr0", if_instr, 32'h0);
    sb.delete();
    repeat (2) tick();
    mem_delay = 0;
    sb.push_back(32'h100);
    rst_n = 1'b1;
    wait_req("rmt_restart");
    chk("rmt_restart_addr", imem_addr, 32'h100);
    halt = 1'b1;
    repeat (6) tick();
    chk("rmt_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
